// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, instruction field positions, fetch FSM encoding
// and the default reset PC. Used by fetch, decode and control_unit.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_MSB  = 25;
  localparam int JADDR_LSB  = 0;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_HOLD  = 2'd1,
    FS_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-high reset to RESET_PC, loads pc_d_i when load_i.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] pc_d_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= pc_d_i;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, req/ack instruction-memory fetch, instruction register and field
// slicing toward decode, with redirect (branch/jump) squash and in-flight request draining.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  input  logic         id_ready,
  output logic         if_valid,
  output logic [5:0]   opcode,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [4:0]   shamt,
  output logic [5:0]   funct,
  output logic [15:0]  imm16,
  output logic [25:0]  jaddr,
  output logic [31:0]  pc_plus4,
  output fetch_state_e dbg_state
);

  // Handshakes: imem_req stays high with imem_addr stable until the one-cycle imem_ack;
  // an instruction transfers to decode on a cycle where if_valid and id_ready are both high,
  // and outputs hold unchanged otherwise. redirect overrides both handshakes.

  fetch_state_e state_q, state_d;
  logic [31:0]  ir_q, ir_d;
  logic [31:0]  pc_plus4_q, pc_plus4_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         valid_q, valid_d;
  logic         pc_load;
  logic [31:0]  pc_next;
  logic [31:0]  pc;
  logic [31:0]  pc_inc;
  logic [31:0]  target;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (pc_load),
    .pc_d_i (pc_next),
    .pc_o   (pc)
  );

  assign pc_inc = pc + 32'd4;
  assign target = word_align(redirect_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FS_FETCH;
      ir_q         <= 32'h0;
      pc_plus4_q   <= 32'h0;
      drain_addr_q <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      pc_plus4_q   <= pc_plus4_d;
      drain_addr_q <= drain_addr_d;
      valid_q      <= valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    pc_plus4_d   = pc_plus4_q;
    drain_addr_d = drain_addr_q;
    valid_d      = valid_q;
    pc_load      = 1'b0;
    pc_next      = pc_inc;
    case (state_q)
      FS_FETCH: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_next = target;
          // An un-acked request cannot be withdrawn; park its address and discard the reply.
          if (!imem_ack) begin
            state_d      = FS_DRAIN;
            drain_addr_d = pc;
          end
        end else if (imem_ack) begin
          ir_d       = imem_rdata;
          pc_plus4_d = pc_inc;
          pc_load    = 1'b1;
          pc_next    = pc_inc;
          valid_d    = 1'b1;
          state_d    = FS_HOLD;
        end
      end
      FS_HOLD: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_next = target;
          valid_d = 1'b0;
          state_d = FS_FETCH;
        end else if (id_ready) begin
          valid_d = 1'b0;
          state_d = FS_FETCH;
        end
      end
      FS_DRAIN: begin
        if (redirect) begin
          pc_load = 1'b1;
          pc_next = target;
        end
        if (imem_ack) begin
          state_d = FS_FETCH;
        end
      end
      default: state_d = FS_FETCH;
    endcase
  end

  assign imem_req  = (state_q != FS_HOLD) && !rst;
  assign imem_addr = (state_q == FS_DRAIN) ? drain_addr_q : pc;
  assign if_valid  = valid_q;
  assign opcode    = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign rs        = ir_q[RS_MSB:RS_LSB];
  assign rt        = ir_q[RT_MSB:RT_LSB];
  assign rd        = ir_q[RD_MSB:RD_LSB];
  assign shamt     = ir_q[SHAMT_MSB:SHAMT_LSB];
  assign funct     = ir_q[FUNCT_MSB:FUNCT_LSB];
  assign imm16     = ir_q[IMM_MSB:IMM_LSB];
  assign jaddr     = ir_q[JADDR_MSB:JADDR_LSB];
  assign pc_plus4  = pc_plus4_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed reset/hold/redirect/drain/wrap cases, then random
// memory latency, redirects and decode stalls checked against an architectural PC-stream model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst;

  logic        imem_req, imem_ack, redirect, id_ready, if_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  mips_pkg::fetch_state_e dbg_state;

  logic        imem_req_w, imem_ack_w, redirect_w, id_ready_w, if_valid_w;
  logic [31:0] imem_addr_w, imem_rdata_w, redirect_pc_w, pc_plus4_w;
  logic [5:0]  opcode_w, funct_w;
  logic [4:0]  rs_w, rt_w, rd_w, shamt_w;
  logic [15:0] imm16_w;
  logic [25:0] jaddr_w;
  mips_pkg::fetch_state_e dbg_state_w;

  int n_checks;
  int n_pass;

  instruction_fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready), .if_valid(if_valid),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .jaddr(jaddr), .pc_plus4(pc_plus4), .dbg_state(dbg_state)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ack(imem_ack_w),
    .imem_rdata(imem_rdata_w), .redirect(redirect_w), .redirect_pc(redirect_pc_w),
    .id_ready(id_ready_w), .if_valid(if_valid_w),
    .opcode(opcode_w), .rs(rs_w), .rt(rt_w), .rd(rd_w), .shamt(shamt_w), .funct(funct_w),
    .imm16(imm16_w), .jaddr(jaddr_w), .pc_plus4(pc_plus4_w), .dbg_state(dbg_state_w)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_word(input string tag, input logic [31:0] w);
    check({tag, "_opcode"}, {26'h0, opcode}, {26'h0, w[31:26]});
    check({tag, "_rs"},     {27'h0, rs},     {27'h0, w[25:21]});
    check({tag, "_rt"},     {27'h0, rt},     {27'h0, w[20:16]});
    check({tag, "_rd"},     {27'h0, rd},     {27'h0, w[15:11]});
    check({tag, "_shamt"},  {27'h0, shamt},  {27'h0, w[10:6]});
    check({tag, "_funct"},  {26'h0, funct},  {26'h0, w[5:0]});
    check({tag, "_imm16"},  {16'h0, imm16},  {16'h0, w[15:0]});
    check({tag, "_jaddr"},  {6'h0, jaddr},   {6'h0, w[25:0]});
  endtask

  initial begin
    logic [31:0] exp_pc, prev_addr, prev_word, prev_pp4;
    logic        prev_valid, prev_req, prev_ack, prev_redirect, prev_accept;
    int          resp_cnt, idle;

    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    imem_ack_w = 1'b0; imem_rdata_w = 32'h0; redirect_w = 1'b0; redirect_pc_w = 32'h0;
    id_ready_w = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_valid", if_valid, 0);
    check("rst_req", imem_req, 0);
    check("rst_opcode", opcode, 0);
    check("rst_pp4", pc_plus4, 0);

    // Basic fetch of a lw
    rst = 1'b0;
    #1;
    check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t1_valid", if_valid, 1);
    check("t1_opcode", opcode, 32'h23);
    check("t1_rs", rs, 1);
    check("t1_rt", rt, 2);
    check("t1_imm16", imm16, 4);
    check("t1_pp4", pc_plus4, 4);
    check("t1_req_hold", imem_req, 0);

    // Decode stalls; a stray ack in the middle must be ignored
    for (int i = 0; i < 5; i++) begin
      imem_ack = (i == 2); imem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("t2_valid", if_valid, 1);
      check("t2_word", {opcode, jaddr}, 32'h8C22_0004);
      check("t2_pp4", pc_plus4, 4);
      check("t2_req", imem_req, 0);
    end
    imem_ack = 1'b0;
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    check("t1_next_valid", if_valid, 0);
    check("t1_next_addr", imem_addr, 32'h4);
    check("t1_next_req", imem_req, 1);
    imem_ack = 1'b1; imem_rdata = mem_word(32'h4);
    @(negedge clk);
    imem_ack = 1'b0;
    check("t1b_valid", if_valid, 1);
    check("t1b_pp4", pc_plus4, 32'h8);

    // Redirect in HOLD beats id_ready
    redirect = 1'b1; redirect_pc = 32'h40; id_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0; id_ready = 1'b0;
    check("t3_valid", if_valid, 0);
    check("t3_addr", imem_addr, 32'h40);
    check("t3_req", imem_req, 1);

    // Redirect under an outstanding request; low target bits must be dropped
    redirect = 1'b1; redirect_pc = 32'h83;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      redirect = 1'b0;
      check("t4_addr_held", imem_addr, 32'h40);
      check("t4_req", imem_req, 1);
      check("t4_valid", if_valid, 0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    check("t4_discard_valid", if_valid, 0);
    check("t4_new_addr", imem_addr, 32'h80);
    imem_ack = 1'b1; imem_rdata = mem_word(32'h80);
    @(negedge clk);
    imem_ack = 1'b0;
    check("t4_valid", if_valid, 1);
    check("t4_pp4", pc_plus4, 32'h84);
    check_word("t4", mem_word(32'h80));

    // Async reset while holding an instruction, then while requesting
    rst = 1'b1;
    #1;
    check("t6_valid", if_valid, 0);
    check("t6_opcode", opcode, 0);
    check("t6_req", imem_req, 0);
    check("t6_pp4", pc_plus4, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_restart_addr", imem_addr, 32'h0);
    check("t6_restart_req", imem_req, 1);
    rst = 1'b1;
    #1;
    check("t6_req_in_rst", imem_req, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_restart2_addr", imem_addr, 32'h0);

    // PC wrap on the second instance
    check("t5_addr", imem_addr_w, 32'hFFFF_FFFC);
    imem_ack_w = 1'b1; imem_rdata_w = mem_word(32'hFFFF_FFFC);
    @(negedge clk);
    imem_ack_w = 1'b0;
    check("t5_valid", if_valid_w, 1);
    check("t5_pp4", pc_plus4_w, 32'h0);
    check("t5_word", {opcode_w, jaddr_w}, mem_word(32'hFFFF_FFFC));
    id_ready_w = 1'b1;
    @(negedge clk);
    id_ready_w = 1'b0;
    check("t5_next_addr", imem_addr_w, 32'h0);
    check("t5_next_req", imem_req_w, 1);

    // Random phase: the model tracks only the architectural address of the next instruction
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_pc = 32'h0;
    prev_valid = 0; prev_req = 0; prev_ack = 0; prev_redirect = 0; prev_accept = 0;
    prev_addr = 0; prev_word = 0; prev_pp4 = 0;
    resp_cnt = -1;
    idle = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_req_vs_valid", imem_req, !if_valid);
      if (prev_redirect) check("rnd_squash", if_valid, 0);
      if (prev_accept) check("rnd_accept_drop", if_valid, 0);
      if (prev_req && !prev_ack) begin
        check("rnd_req_held", imem_req, 1);
        check("rnd_addr_stable", imem_addr, prev_addr);
      end
      if (if_valid && !prev_valid) begin
        check("rnd_pp4", pc_plus4, exp_pc + 32'd4);
        check_word("rnd", mem_word(exp_pc));
        idle = 0;
      end else if (if_valid && prev_valid) begin
        check("rnd_hold_word", {opcode, jaddr}, prev_word);
        check("rnd_hold_pp4", pc_plus4, prev_pp4);
      end
      idle++;
      if (idle > 200) begin
        check("rnd_liveness", 0, 1);
        break;
      end

      prev_valid = if_valid;
      prev_req   = imem_req;
      prev_addr  = imem_addr;
      prev_word  = {opcode, jaddr};
      prev_pp4   = pc_plus4;

      // Driver
      redirect = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      else redirect_pc = $urandom & 32'h0000_03FF;
      id_ready = $urandom_range(0, 1);
      imem_ack = 1'b0;
      if (imem_req) begin
        if (resp_cnt < 0) resp_cnt = $urandom_range(0, 3);
        if (resp_cnt == 0) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
          resp_cnt = -1;
        end else begin
          resp_cnt--;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        imem_ack = 1'b1;
        imem_rdata = $urandom;
      end

      // Reference model
      prev_ack      = imem_ack && imem_req;
      prev_redirect = redirect;
      prev_accept   = if_valid && id_ready && !redirect;
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      else if (if_valid && id_ready) exp_pc = exp_pc + 32'd4;

      @(negedge clk);
    end
    redirect = 1'b0;
    imem_ack = 1'b0;
    id_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
